bidir_routing_block_cfg: RTL and testbench
==========================================

// Module: bidir_routing_block_cfg
// PURPOSE
//  Parametrised successor of the 3-track bidirectional switch box: W tracks per side, 4 sides.
//  Adds a serial config chain (shadow reg) plus atomic commit to an active reg.
//  Adds a hardware check that rejects configs whose tracks drive each other.
//  Tiles daisy-chain cfg_sdo -> cfg_sdi to form the fabric configuration chain.
// PARAMETERS
//  W        3   tracks per side; CFG_BITS = 8*W (2-bit field per destination track)
// PORTS
//  clk          in     1        single clock
//  rst          in     1        synchronous, active-high reset
//  cfg_sdi      in     1        serial config in
//  cfg_shift    in     1        shift enable (IDLE only)
//  cfg_commit   in     1        1-cycle pulse: check shadow, then apply
//  cfg_sdo      out    1        serial out = shadow[CFG_BITS-1] (combinational from reg)
//  cfg_busy     out    1        high while commit in progress
//  cfg_err      out    1        last commit rejected (loop found)
//  left,top,right,bottom inout W  track nets; side idx 0=left,1=top,2=right,3=bottom (clockwise)
// BEHAVIOUR
//  Reset: shadow=0, active=0 (all tracks hi-Z), cfg_busy=0, cfg_err=0, state=IDLE.
//  Reset mid-commit aborts the commit; active returns to 0.
//  Field of dest side s, track t: idx = s*W+t, bits [2*idx+:2]. f=0 -> dest undriven (z).
//  f!=0 -> dest driven by track t of side (s+f)%4. Disjoint box: track t only reaches track t.
//  Routing is combinational from the active reg: dest = f ? src_net : 1'bz.
//  Shift (IDLE, cfg_shift=1, cfg_commit=0): shadow <= {shadow[CFG_BITS-2:0], cfg_sdi}.
//  FSM IDLE -> CHECK on cfg_commit (commit wins over a same-cycle shift; that shift is dropped).
//  CHECK: idx = 0..4W-1, one idx per cycle, cfg_busy=1.
//   Loop: f!=0, src=(s+f)%4, g=src's field for track t, g!=0 and (src+g)%4==s. Sets a sticky flag.
//   At idx 4W-1: flag=0 -> APPLY; flag=1 -> cfg_err=1, active unchanged, -> IDLE.
//  APPLY (1 cycle): active <= shadow, cfg_err <= 0, -> IDLE.
//  Commit latency: active updates on the edge ending cycle 4W+1 after the commit edge.
//  cfg_busy falls the same cycle.
//  cfg_shift and cfg_commit are ignored while busy; shadow is frozen in CHECK/APPLY.
//  Arithmetic: side index mod 4 on 2-bit wrap; idx counter width $clog2(4*W).
//  cfg_err holds until the next commit resolves (cleared only by APPLY or reset).
// CONFIGURATION
//  LOOP_CHECK_EN defined: CHECK state present as above.
//  LOOP_CHECK_EN undefined: commit goes IDLE -> APPLY directly (busy for 1 cycle).
//   cfg_err tied to 0; loops are the user's responsibility.
// STRUCTURE
//  bidir_routing_pkg: side encodings (SIDE_L/T/R/B), FIELD_W=2, FSM state enum.
//   Also holds function src_side(s,f) and cfg_bits(W).
//  Sub-module bidir_cfg_loop_check: combinational per-idx loop test (shadow, idx) -> hit.
//  Top holds shift reg, active reg, FSM/counter, tristate drivers.
// TESTING
//  1 Reset, all nets released by bench -> all 4*W track outputs z; cfg_busy=0, cfg_err=0.
//  2 Shift 24 bits with only bit7=1 (top[0]<-bottom[0]), commit -> busy 13 cycles, err=0.
//    Then bottom[0]=1 -> top[0]=1 and bottom[0]=0 -> top[0]=0; other tracks z.
//  3 From case 2, add bit19=1 (bottom[0]<-top[0]), commit -> after 12 CHECK cycles err=1.
//    Active unchanged, top[0] still follows bottom[0].
//  4 Pulse cfg_shift/cfg_commit during busy -> shadow and FSM unaffected; cfg_sdo stable.
//  5 Shift pattern P (24 bits), then 24 more shifts -> cfg_sdo reproduces P in order.
//  6 Assert rst in CHECK cycle 5 -> next cycle busy=0, err=0, all tracks z.
//    Build without LOOP_CHECK_EN: case 3 applies, busy 1 cycle.

Source files
------------

// File: rtl/bidir_routing_pkg.sv
// Shared types and helpers for the configurable bidirectional switch box.
package bidir_routing_pkg;

    localparam int unsigned FIELD_W   = 2;
    localparam int unsigned NUM_SIDES = 4;

    typedef logic [1:0] side_t;

    // Sides numbered clockwise so (s + f) mod 4 walks around the box.
    localparam side_t SIDE_L = 2'd0;
    localparam side_t SIDE_T = 2'd1;
    localparam side_t SIDE_R = 2'd2;
    localparam side_t SIDE_B = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StApply
    } state_e;

    // Source side for a destination side s with non-zero field f; 2-bit wrap gives mod 4.
    function automatic side_t src_side(input side_t s, input logic [FIELD_W-1:0] f);
        return side_t'(s + side_t'(f));
    endfunction

    function automatic int unsigned cfg_bits(input int unsigned w);
        return NUM_SIDES * FIELD_W * w;
    endfunction

endpackage

// File: rtl/bidir_routing_block_cfg_loop_check.sv
// Combinational test of one destination track: does it form a two-track drive loop
// with the track it selects as source?
module bidir_cfg_loop_check
    import bidir_routing_pkg::*;
#(
    parameter int unsigned W    = 3,
    parameter int unsigned IdxW = $clog2(NUM_SIDES * W)
) (
    input  logic [cfg_bits(W)-1:0] shadow_i,
    input  logic [IdxW-1:0]        idx_i,
    output logic                   hit_o
);

    logic [FIELD_W-1:0] fld;
    logic [FIELD_W-1:0] gld;
    side_t              src;

    // Decode idx into (side, track) and compare the pair of fields pointing at each other.
    always_comb begin
        hit_o = 1'b0;
        fld   = '0;
        gld   = '0;
        src   = '0;
        for (int unsigned s = 0; s < NUM_SIDES; s++) begin
            for (int unsigned t = 0; t < W; t++) begin
                if (idx_i == IdxW'(s * W + t)) begin
                    fld   = shadow_i[FIELD_W * (s * W + t) +: FIELD_W];
                    src   = src_side(side_t'(s), fld);
                    gld   = shadow_i[FIELD_W * (32'(src) * W + t) +: FIELD_W];
                    hit_o = (fld != '0) && (gld != '0) && (src_side(src, gld) == side_t'(s));
                end
            end
        end
    end

endmodule

// File: rtl/bidir_routing_block_cfg.sv
// Configurable W-track bidirectional switch box with serial config chain and atomic commit.
// Optional feature macro: LOOP_CHECK_EN (adds the CHECK state that rejects looped configs).
module bidir_routing_block_cfg
    import bidir_routing_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_sdi,
    input  logic         cfg_shift,
    input  logic         cfg_commit,
    output logic         cfg_sdo,
    output logic         cfg_busy,
    output logic         cfg_err,
    inout  wire  [W-1:0] left,
    inout  wire  [W-1:0] top,
    inout  wire  [W-1:0] right,
    inout  wire  [W-1:0] bottom
);

    localparam int unsigned CfgBits = cfg_bits(W);
    localparam int unsigned NumIdx  = NUM_SIDES * W;
    localparam int unsigned IdxW    = $clog2(NumIdx);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumIdx - 1);

    state_e               state_q, state_d;
    logic [CfgBits-1:0]   shadow_q, shadow_d;
    logic [CfgBits-1:0]   active_q, active_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 flag_q, flag_d;
    logic                 err_q, err_d;
    logic                 hit;

    bidir_cfg_loop_check #(
        .W    (W),
        .IdxW (IdxW)
    ) u_loop_check (
        .shadow_i (shadow_q),
        .idx_i    (idx_q),
        .hit_o    (hit)
    );

    // Next-state: shifting in IDLE, sweep of all destinations in CHECK, single-cycle APPLY.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        idx_d    = idx_q;
        flag_d   = flag_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                // Commit takes priority; a same-cycle shift is dropped.
                if (cfg_commit) begin
                    idx_d  = '0;
                    flag_d = 1'b0;
`ifdef LOOP_CHECK_EN
                    state_d = StCheck;
`else
                    state_d = StApply;
`endif
                end else if (cfg_shift) begin
                    shadow_d = {shadow_q[CfgBits-2:0], cfg_sdi};
                end
            end
            StCheck: begin
                flag_d = flag_q | hit;
                if (idx_q == LastIdx) begin
                    if (flag_q | hit) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StApply;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StApply: begin
                active_d = shadow_q;
                err_d    = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also aborts any commit in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            active_q <= '0;
            idx_q    <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            idx_q    <= idx_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
        end
    end

    assign cfg_sdo  = shadow_q[CfgBits-1];
    assign cfg_busy = (state_q != StIdle);

`ifdef LOOP_CHECK_EN
    assign cfg_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
    assign cfg_err    = 1'b0;
`endif

    // Track routing: gather side nets, pick the source per destination from the active config.
    logic [NUM_SIDES-1:0][W-1:0] net_in;
    logic [NUM_SIDES-1:0][W-1:0] drv_en;
    logic [NUM_SIDES-1:0][W-1:0] drv_val;
    logic [FIELD_W-1:0]          rfld;

    assign net_in[SIDE_L] = left;
    assign net_in[SIDE_T] = top;
    assign net_in[SIDE_R] = right;
    assign net_in[SIDE_B] = bottom;

    // Combinational route selection from the active register.
    always_comb begin
        drv_en  = '0;
        drv_val = '0;
        rfld    = '0;
        for (int unsigned s = 0; s < NUM_SIDES; s++) begin
            for (int unsigned t = 0; t < W; t++) begin
                rfld          = active_q[FIELD_W * (s * W + t) +: FIELD_W];
                drv_en[s][t]  = (rfld != '0);
                drv_val[s][t] = net_in[src_side(side_t'(s), rfld)][t];
            end
        end
    end

    for (genvar t = 0; t < W; t++) begin : g_trk
        assign left[t]   = drv_en[SIDE_L][t] ? drv_val[SIDE_L][t] : 1'bz;
        assign top[t]    = drv_en[SIDE_T][t] ? drv_val[SIDE_T][t] : 1'bz;
        assign right[t]  = drv_en[SIDE_R][t] ? drv_val[SIDE_R][t] : 1'bz;
        assign bottom[t] = drv_en[SIDE_B][t] ? drv_val[SIDE_B][t] : 1'bz;
    end

endmodule

// File: tb/tb_bidir_routing_block_cfg.sv
// Bench for bidir_routing_block_cfg: directed cases plus random configs against a
// graph-level model of the switch box. Honours LOOP_CHECK_EN like the design.
module tb_bidir_routing_block_cfg;

    localparam int unsigned W  = 3;
    localparam int unsigned NI = 4 * W;
    localparam int unsigned CB = 8 * W;
`ifdef LOOP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, sdi, shift, commit;
    logic sdo, busy, err;
    wire [W-1:0] left, top, right, bottom;

    logic [3:0][W-1:0] tb_en, tb_val;
    logic [NI-1:0]     obs_z, obs_v;

    logic [CB-1:0] m_sh, m_act;
    logic          m_err;
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    bidir_routing_block_cfg #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_sdi    (sdi),
        .cfg_shift  (shift),
        .cfg_commit (commit),
        .cfg_sdo    (sdo),
        .cfg_busy   (busy),
        .cfg_err    (err),
        .left       (left),
        .top        (top),
        .right      (right),
        .bottom     (bottom)
    );

    for (genvar t = 0; t < W; t++) begin : g_net
        assign left[t]   = tb_en[0][t] ? tb_val[0][t] : 1'bz;
        assign top[t]    = tb_en[1][t] ? tb_val[1][t] : 1'bz;
        assign right[t]  = tb_en[2][t] ? tb_val[2][t] : 1'bz;
        assign bottom[t] = tb_en[3][t] ? tb_val[3][t] : 1'bz;
        assign obs_z[0*W+t] = (left[t] === 1'bz);
        assign obs_z[1*W+t] = (top[t] === 1'bz);
        assign obs_z[2*W+t] = (right[t] === 1'bz);
        assign obs_z[3*W+t] = (bottom[t] === 1'bz);
        assign obs_v[0*W+t] = left[t];
        assign obs_v[1*W+t] = top[t];
        assign obs_v[2*W+t] = right[t];
        assign obs_v[3*W+t] = bottom[t];
    end

    function automatic logic [1:0] fld(input logic [CB-1:0] c, input int s, input int t);
        return c[2*(s*W+t) +: 2];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Two tracks that select each other as source.
    function automatic bit has_loop(input logic [CB-1:0] c);
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < W; t++) begin
                int f = int'(fld(c, s, t));
                if (f != 0) begin
                    int src = (s + f) % 4;
                    int g   = int'(fld(c, src, t));
                    if (g != 0 && (src + g) % 4 == s) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // Drop fields that close cycles the hardware cannot reject (or any cycle without checking).
    function automatic logic [CB-1:0] fix_cycles(input logic [CB-1:0] c);
        logic [CB-1:0] r = c;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < W; t++) begin
                int cur = s;
                for (int hop = 1; hop <= 4; hop++) begin
                    int f = int'(fld(r, cur, t));
                    if (f == 0) break;
                    cur = (cur + f) % 4;
                    if (cur == s) begin
                        if (hop >= 3 || !CHK) r[2*(s*W+t) +: 2] = 2'b00;
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    // Expected net: 0/1 value, 2 = high-Z, 3 = not checkable (undriven chain end or loop).
    function automatic int resolve(input int s, input int t);
        int cur = s;
        for (int hop = 0; hop <= 4; hop++) begin
            int f = int'(fld(m_act, cur, t));
            if (f == 0) begin
                if (tb_en[cur][t]) return int'(tb_val[cur][t]);
                return (hop == 0) ? 2 : 3;
            end
            cur = (cur + f) % 4;
        end
        return 3;
    endfunction

    task automatic check_nets(input string tag);
        #1;
        for (int i = 0; i < NI; i++) begin
            int e = resolve(i / W, i % W);
            if (e != 3) begin
                chk($sformatf("%s z s%0dt%0d", tag, i / W, i % W), obs_z[i], e == 2);
                if (e != 2) chk($sformatf("%s v s%0dt%0d", tag, i / W, i % W), obs_v[i], e[0]);
            end
        end
    endtask

    task automatic set_drivers(input logic [NI-1:0] allow, input bit both);
        for (int i = 0; i < NI; i++) begin
            int s = i / W;
            int t = i % W;
            tb_en[s][t]  = allow[i] && fld(m_act, s, t) == 2'b00 &&
                           (!both || fld(m_sh, s, t) == 2'b00);
            tb_val[s][t] = 1'($urandom);
        end
    endtask

    task automatic shift_cfg(input logic [CB-1:0] c);
        for (int i = CB - 1; i >= 0; i--) begin
            sdi   = c[i];
            shift = 1'b1;
            tick();
            m_sh = {m_sh[CB-2:0], c[i]};
        end
        shift = 1'b0;
        chk("sdo after load", sdo, m_sh[CB-1]);
    endtask

    task automatic do_commit(input bit poke, input int rst_at);
        int  cnt;
        int  exp_busy;
        bit  lp;
        lp       = has_loop(m_sh);
        exp_busy = !CHK ? 1 : (lp ? NI : NI + 1);
        commit   = 1'b1;
        tick();
        commit = 1'b0;
        cnt    = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == rst_at) begin
                rst = 1'b1;
                tick();
                rst   = 1'b0;
                m_sh  = '0;
                m_act = '0;
                m_err = 1'b0;
                chk("busy after rst", busy, 1'b0);
                chk("err after rst", err, 1'b0);
                return;
            end
            if (poke) begin
                shift  = (cnt >= 2 && cnt <= 4);
                commit = (cnt >= 2 && cnt <= 4);
                sdi    = 1'($urandom);
                chk("sdo frozen", sdo, m_sh[CB-1]);
            end
            tick();
        end
        shift  = 1'b0;
        commit = 1'b0;
        chk_int("busy cycles", cnt, exp_busy);
        if (!CHK || !lp) begin
            m_act = m_sh;
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        chk("err", err, m_err);
    endtask

    initial begin
        logic [CB-1:0] c;
        logic [CB-1:0] p;
        logic [NI-1:0] only_b0;
        rst    = 1'b1;
        sdi    = 1'b0;
        shift  = 1'b0;
        commit = 1'b0;
        tb_en  = '0;
        tb_val = '0;
        m_sh   = '0;
        m_act  = '0;
        m_err  = 1'b0;
        only_b0 = '0;
        only_b0[3*W] = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", busy, 1'b0);
        chk("reset err", err, 1'b0);
        chk("reset sdo", sdo, 1'b0);
        check_nets("reset");

        // top[0] <- bottom[0]
        c = '0;
        c[7] = 1'b1;
        shift_cfg(c);
        set_drivers(only_b0, 1'b1);
        do_commit(1'b0, 0);
        set_drivers(only_b0, 1'b0);
        tb_val[3][0] = 1'b1;
        check_nets("route b0=1");
        tb_val[3][0] = 1'b0;
        check_nets("route b0=0");

        // Add bottom[0] <- top[0]: two-track loop
        c[19] = 1'b1;
        shift_cfg(c);
        set_drivers(only_b0, 1'b1);
        do_commit(1'b0, 0);
        set_drivers(only_b0, 1'b0);
        tb_val[3][0] = 1'b1;
        check_nets("loop b0=1");
        tb_val[3][0] = 1'b0;
        check_nets("loop b0=0");

        // Reset in the middle of a commit
        tb_en = '0;
        do_commit(1'b0, CHK ? 5 : 1);
        chk("sdo after rst", sdo, 1'b0);
        check_nets("mid-commit rst");

        // Shift/commit pokes while busy
        c = '0;
        c[7] = 1'b1;
        c[2*(2*W+1) +: 2] = 2'b11;
        shift_cfg(c);
        set_drivers('1, 1'b1);
        do_commit(1'b1, 0);
        chk("idle after poke", busy, 1'b0);
        set_drivers('1, 1'b0);
        check_nets("poke");

        // Chain replay through cfg_sdo
        p = {$urandom, $urandom};
        shift_cfg(p);
        for (int k = 0; k < CB; k++) begin
            chk($sformatf("sdo replay %0d", k), sdo, p[CB-1-k]);
            sdi   = 1'($urandom);
            shift = 1'b1;
            tick();
            m_sh = {m_sh[CB-2:0], sdi};
        end
        shift = 1'b0;

        // Random configurations
        for (int it = 0; it < 16; it++) begin
            c = '0;
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 9) < 6) c[2*i +: 2] = 2'($urandom_range(1, 3));
            end
            c = fix_cycles(c);
            shift_cfg(c);
            set_drivers('1, 1'b1);
            do_commit(1'b0, 0);
            set_drivers('1, 1'b0);
            check_nets($sformatf("rnd%0d a", it));
            set_drivers('1, 1'b0);
            check_nets($sformatf("rnd%0d b", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
